// File: rtl/dec_mult_pkg.sv
// dec_mult_pkg: shared states, widths and BCD digit-validity helpers for the decimal multiplier sequencer
package dec_mult_pkg;
  localparam int DIGITS = 4;
  localparam int BCD_W = 16;
  localparam int PROD_W = 32;
  typedef enum logic [2:0] {S_IDLE, S_REC_A, S_REC_B, S_ISSUE, S_DRAIN, S_DONE} state_e;
  function automatic logic digit_ok(input logic [3:0] d);
    return d <= 4'd9;
  endfunction
  function automatic logic operand_ok(input logic [BCD_W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) ok &= digit_ok(v[4*i +: 4]);
    return ok;
  endfunction
endpackage

// File: rtl/dec_mult_seq_fsm.sv
// dec_mult_seq_fsm: state register, digit and drain counters; start_i/ok_i/out_ready_i in, state_o/digit_o/latch_o out
module dec_mult_seq_fsm
  import dec_mult_pkg::*;
#(
  parameter int ACC_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       ok_i,
  input  logic       out_ready_i,
  output state_e     state_o,
  output logic [1:0] digit_o,
  output logic       latch_o
);
  localparam logic [1:0] DIGIT_LAST = 2'(DIGITS - 1);
  localparam logic [2:0] DRAIN_LAST = 3'(ACC_LAT - 1);
  state_e state_q, state_d;
  logic [1:0] dig_q, dig_d;
  logic [2:0] drn_q, drn_d;
  always_comb begin
    state_d = state_q;
    dig_d = dig_q;
    drn_d = drn_q;
    latch_o = 1'b0;
    case (state_q)
      S_IDLE: state_d = start_i ? (ok_i ? S_REC_A : S_DONE) : S_IDLE;
      S_REC_A: state_d = S_REC_B;
      S_REC_B: begin
        state_d = S_ISSUE;
        dig_d = '0;
      end
      S_ISSUE: begin
        dig_d = dig_q + 2'd1;
        drn_d = '0;
        if (dig_q == DIGIT_LAST) begin
          state_d = ACC_LAT == 0 ? S_DONE : S_DRAIN;
          latch_o = ACC_LAT == 0;
        end
      end
      S_DRAIN: begin
        drn_d = drn_q + 3'd1;
        if (drn_q == DRAIN_LAST) begin
          state_d = S_DONE;
          latch_o = 1'b1;
        end
      end
      S_DONE: state_d = out_ready_i ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dig_q <= '0;
      drn_q <= '0;
    end else begin
      state_q <= state_d;
      dig_q <= dig_d;
      drn_q <= drn_d;
    end
  end
  assign state_o = state_q;
  assign digit_o = dig_q;
endmodule

// File: rtl/dec_mult_seq.sv
// dec_mult_seq: BCD multiply sequencer; operands in (in_valid/in_ready, a_bcd, b_bcd), shared recoder (rec_in/rec_out), datapath control (mcand_5421, pp_*, acc_*, acc_result), result out (out_valid/out_ready, prod, err)
module dec_mult_seq
  import dec_mult_pkg::*;
#(
  parameter int ACC_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BCD_W-1:0]  a_bcd,
  input  logic [BCD_W-1:0]  b_bcd,
  output logic [BCD_W-1:0]  rec_in,
  input  logic [BCD_W-1:0]  rec_out,
  output logic [BCD_W-1:0]  mcand_5421,
  output logic [3:0]        pp_digit,
  output logic              pp_en,
  output logic              acc_clr,
  output logic              acc_shift,
  input  logic [PROD_W-1:0] acc_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] prod,
  output logic              err
);
  state_e state;
  logic [1:0] digit;
  logic latch, start, ok, issue;
  logic [BCD_W-1:0] a_q, a_d, b_q, b_d, mcand_q, mcand_d, b5421_q, b5421_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic err_q, err_d;
  dec_mult_seq_fsm #(.ACC_LAT(ACC_LAT)) u_fsm (
    .clk(clk),
    .rst(rst),
    .start_i(start),
    .ok_i(ok),
    .out_ready_i(out_ready),
    .state_o(state),
    .digit_o(digit),
    .latch_o(latch)
  );
  assign in_ready = state == S_IDLE;
  assign start = in_valid && in_ready;
  assign ok = operand_ok(a_bcd) && operand_ok(b_bcd);
  assign issue = state == S_ISSUE;
  always_comb begin
    a_d = start ? a_bcd : a_q;
    b_d = start ? b_bcd : b_q;
    mcand_d = state == S_REC_A ? rec_out : mcand_q;
    b5421_d = state == S_REC_B ? rec_out : b5421_q;
    err_d = start ? !ok : err_q;
    prod_d = start && !ok ? '0 : latch ? acc_result : prod_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      mcand_q <= '0;
      b5421_q <= '0;
      prod_q <= '0;
      err_q <= 1'b0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      mcand_q <= mcand_d;
      b5421_q <= b5421_d;
      prod_q <= prod_d;
      err_q <= err_d;
    end
  end
  assign rec_in = state == S_REC_A ? a_q : state == S_REC_B ? b_q : '0;
  assign pp_digit = issue ? b5421_q[{digit, 2'b00} +: 4] : 4'd0;
  assign pp_en = issue && pp_digit != 4'd0;
  assign acc_shift = issue && digit != 2'd0;
  assign acc_clr = start && ok;
  assign out_valid = state == S_DONE;
  assign mcand_5421 = mcand_q;
  assign prod = prod_q;
  assign err = err_q;
endmodule

// File: tb/tb_dec_mult_seq.sv
// tb_dec_mult_seq: randomized and directed checks of three latency builds against a behavioural recoder/accumulator
module tb_dec_mult_seq;
  logic clk = 1'b0;
  logic rst, in_valid, out_ready;
  logic [15:0] a_bcd, b_bcd;
  int errors = 0;
  int checks = 0;
  logic in_ready_w [3];
  logic [15:0] rec_in_w [3];
  logic [15:0] rec_out_w [3];
  logic [15:0] mcand_w [3];
  logic [3:0] pp_digit_w [3];
  logic pp_en_w [3];
  logic acc_clr_w [3];
  logic acc_shift_w [3];
  logic [31:0] acc_res_w [3];
  logic out_valid_w [3];
  logic [31:0] prod_w [3];
  logic err_w [3];
  always #5 clk = ~clk;
  function automatic int lat_of(input int k);
    return k == 0 ? 1 : k == 1 ? 0 : 7;
  endfunction
  function automatic logic [15:0] rec5421(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = v[4*i +: 4] < 4'd5 ? v[4*i +: 4] : v[4*i +: 4] + 4'd3;
    return r;
  endfunction
  function automatic longint dig5(input logic [3:0] d);
    return d >= 4'd8 ? longint'(d) - 3 : longint'(d);
  endfunction
  function automatic longint val5421(input logic [15:0] v);
    longint s;
    s = 0;
    for (int i = 3; i >= 0; i--) s = s * 10 + dig5(v[4*i +: 4]);
    return s;
  endfunction
  function automatic longint bcd2int(input logic [15:0] v);
    longint s;
    s = 0;
    for (int i = 3; i >= 0; i--) s = s * 10 + longint'(v[4*i +: 4]);
    return s;
  endfunction
  function automatic logic [31:0] int2bcd(input longint v);
    logic [31:0] r;
    longint x;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction
  function automatic logic bcd_ok(input logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction
  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int LAT = g == 0 ? 1 : g == 1 ? 0 : 7;
    longint acc_q, acc_n, w_q, w_n;
    logic [31:0] pipe [8];
    dec_mult_seq #(.ACC_LAT(LAT)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready_w[g]),
      .a_bcd(a_bcd),
      .b_bcd(b_bcd),
      .rec_in(rec_in_w[g]),
      .rec_out(rec_out_w[g]),
      .mcand_5421(mcand_w[g]),
      .pp_digit(pp_digit_w[g]),
      .pp_en(pp_en_w[g]),
      .acc_clr(acc_clr_w[g]),
      .acc_shift(acc_shift_w[g]),
      .acc_result(acc_res_w[g]),
      .out_valid(out_valid_w[g]),
      .out_ready(out_ready),
      .prod(prod_w[g]),
      .err(err_w[g])
    );
    assign rec_out_w[g] = rec5421(rec_in_w[g]);
    always_comb begin
      w_n = acc_clr_w[g] ? 1 : acc_shift_w[g] ? w_q * 10 : w_q;
      acc_n = (acc_clr_w[g] ? 0 : acc_q) + (pp_en_w[g] ? dig5(pp_digit_w[g]) * val5421(mcand_w[g]) * w_n : 0);
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        acc_q <= 0;
        w_q <= 1;
      end else begin
        acc_q <= acc_n;
        w_q <= w_n;
      end
      pipe[0] <= int2bcd(acc_n);
      for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    end
    if (LAT == 0) begin : comb_res
      assign acc_res_w[g] = int2bcd(acc_n);
    end else begin : dly_res
      assign acc_res_w[g] = pipe[LAT-1];
    end
  end
  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic wait_idle();
    @(negedge clk);
    for (int n = 0; n < 40 && !(in_ready_w[0] && in_ready_w[1] && in_ready_w[2]); n++) @(negedge clk);
    if (!(in_ready_w[0] && in_ready_w[1] && in_ready_w[2])) check("idle_timeout", 0, 1);
  endtask
  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_in_ready%0d", tag, k), longint'(in_ready_w[k]), 1);
      check($sformatf("%s_out_valid%0d", tag, k), longint'(out_valid_w[k]), 0);
      check($sformatf("%s_prod%0d", tag, k), longint'(prod_w[k]), 0);
      check($sformatf("%s_err%0d", tag, k), longint'(err_w[k]), 0);
      check($sformatf("%s_mcand%0d", tag, k), longint'(mcand_w[k]), 0);
      check($sformatf("%s_ctl%0d", tag, k), longint'({pp_en_w[k], acc_clr_w[k], acc_shift_w[k], pp_digit_w[k], rec_in_w[k]}), 0);
    end
  endtask
  task automatic run_op(input logic [15:0] a, input logic [15:0] b);
    logic exp_e, overlap;
    logic [31:0] exp_p;
    logic [15:0] rb;
    logic [3:0] dg;
    int first [3];
    logic [31:0] p [3];
    logic e [3];
    exp_e = !(bcd_ok(a) && bcd_ok(b));
    exp_p = exp_e ? 32'd0 : int2bcd(bcd2int(a) * bcd2int(b));
    rb = rec5421(b);
    overlap = 1'b0;
    first = '{-1, -1, -1};
    wait_idle();
    in_valid = 1'b1;
    a_bcd = a;
    b_bcd = b;
    #1;
    check("acc_clr", longint'(acc_clr_w[0]), longint'(!exp_e));
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
      a_bcd = 16'($urandom);
      b_bcd = 16'($urandom);
      overlap |= in_ready_w[0] && out_valid_w[0];
      if (n >= 3 && n <= 6) begin
        dg = rb[4*(n-3) +: 4];
        check($sformatf("pp_digit%0d", n - 3), longint'(pp_digit_w[0]), exp_e ? 0 : longint'(dg));
        check($sformatf("pp_en%0d", n - 3), longint'(pp_en_w[0]), longint'(!exp_e && dg != 4'd0));
        check($sformatf("acc_shift%0d", n - 3), longint'(acc_shift_w[0]), longint'(!exp_e && n != 3));
      end
      for (int k = 0; k < 3; k++) if (out_valid_w[k] && first[k] < 0) begin
        first[k] = n;
        p[k] = prod_w[k];
        e[k] = err_w[k];
      end
    end
    check("ready_with_valid", longint'(overlap), 0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("latency%0d", k), longint'(first[k]), exp_e ? 1 : 7 + lat_of(k));
      if (first[k] >= 0) begin
        check($sformatf("prod%0d", k), longint'(p[k]), longint'(exp_p));
        check($sformatf("err%0d", k), longint'(e[k]), longint'(exp_e));
      end
    end
  endtask
  initial begin
    logic [15:0] ra, rb;
    logic [31:0] hold;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a_bcd = '0;
    b_bcd = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    run_op(16'h1234, 16'h5678);
    run_op(16'h5678, 16'h0102);
    run_op(16'h12A4, 16'h1111);
    run_op(16'h0000, 16'h9090);
    wait_idle();
    out_ready = 1'b0;
    in_valid = 1'b1;
    a_bcd = 16'h4321;
    b_bcd = 16'h0987;
    @(negedge clk);
    in_valid = 1'b0;
    for (int n = 0; n < 20 && !out_valid_w[0]; n++) @(negedge clk);
    check("bp_valid", longint'(out_valid_w[0]), 1);
    hold = int2bcd(longint'(4321) * 987);
    check("bp_prod", longint'(prod_w[0]), longint'(hold));
    in_valid = 1'b1;
    a_bcd = 16'h1111;
    b_bcd = 16'h1111;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("bp_hold_valid", longint'(out_valid_w[0]), 1);
      check("bp_hold_prod", longint'(prod_w[0]), longint'(hold));
      check("bp_no_ready", longint'(in_ready_w[0]), 0);
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_release_ready", longint'(in_ready_w[0]), 1);
    check("bp_release_valid", longint'(out_valid_w[0]), 0);
    wait_idle();
    in_valid = 1'b1;
    a_bcd = 16'h1234;
    b_bcd = 16'h5678;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    check("mid_issue_shift", longint'(acc_shift_w[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    run_op(16'h9999, 16'h9999);
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 4; i++) begin
        ra[4*i +: 4] = 4'($urandom_range(0, 9));
        rb[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 4) == 0) begin
        if ($urandom_range(0, 1) == 0) ra[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
        else rb[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
      end
      run_op(ra, rb);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dec_mult_seq.md
DEC_MULT_SEQ -- requirements
Module: dec_mult_seq

Interface
REQ-001 Parameter ACC_LAT, default 1: cycles from the last partial-product issue until acc_result is valid (range 0..7).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operand pair offered.
REQ-005 in_ready  output  1  sequencer accepts operands (high only in IDLE).
REQ-006 a_bcd  input  16  multiplicand, 4 BCD-8421 digits, [3:0] least significant.
REQ-007 b_bcd  input  16  multiplier, same format.
REQ-008 rec_in  output  16  operand driven to the shared 8421-to-5421 recoder.
REQ-009 rec_out  input  16  recoder result for rec_in, combinational, same cycle.
REQ-010 mcand_5421  output  16  registered 5421 multiplicand for the partial-product datapath.
REQ-011 pp_digit  output  4  current 5421 multiplier digit.
REQ-012 pp_en  output  1  partial product valid this cycle; low when the digit is zero.
REQ-013 acc_clr  output  1  one-cycle accumulator clear.
REQ-014 acc_shift  output  1  accumulator shifts one decimal digit before adding; high on every issue cycle except digit 0.
REQ-015 acc_result  input  32  8-digit BCD product from the datapath accumulator.
REQ-016 out_valid  output  1  prod/err valid.
REQ-017 out_ready  input  1  consumer accepts the result.
REQ-018 prod  output  32  registered BCD product.
REQ-019 err  output  1  an operand digit exceeded 9.

Function
REQ-020 States: IDLE, REC_A, REC_B, ISSUE, DRAIN, DONE. Operand transfer occurs on in_valid && in_ready.
REQ-021 IDLE: on transfer, capture a_bcd/b_bcd, check every nibble; if any nibble > 9, go to DONE with err=1 and prod=0; otherwise go to REC_A and pulse acc_clr in the transfer cycle.
REQ-022 REC_A: rec_in = captured A; latch rec_out into mcand_5421; go to REC_B.
REQ-023 REC_B: rec_in = captured B; latch rec_out into the internal B_5421 register; clear the 2-bit digit counter; go to ISSUE.
REQ-024 In all other states rec_in = 16'h0000.
REQ-025 ISSUE: one cycle per digit i = 0..3, starting from the least-significant digit of B. pp_digit = B_5421[4i+3:4i]; pp_en = (digit != 0); acc_shift = (i != 0). After i = 3, go to DRAIN.
REQ-026 pp_digit, pp_en and acc_shift are 0 outside ISSUE.
REQ-027 DRAIN: count ACC_LAT cycles, then latch acc_result into prod and go to DONE. With ACC_LAT = 0, acc_result is latched in the cycle after the last issue.
REQ-028 DONE: out_valid = 1. Hold prod and err stable until out_valid && out_ready, then return to IDLE.
REQ-029 in_ready is never high in the same cycle as out_valid; there is no operand overlap, and the next transfer happens at the earliest in the cycle after the result handshake.
REQ-030 Latency for a valid pair: transfer at cycle T, out_valid first high at T + 7 + ACC_LAT. Error latency: out_valid at T + 1.
REQ-031 in_valid while not in IDLE is ignored. Operand inputs need only be stable in the transfer cycle.

Reset
REQ-032 When rst is high at a clock edge:
- state = IDLE and the counters clear;
- outputs: in_ready = 1; out_valid, err, pp_en, acc_clr, acc_shift = 0; prod, mcand_5421, pp_digit, rec_in = 0.
REQ-033 Reset mid-operation (any state) abandons the operation with no out_valid. The first post-reset transfer behaves exactly as after power-up.

Structure
REQ-034 A shared package dec_mult_pkg holds: the state enum, DIGITS = 4, BCD_W = 16, PROD_W = 32, and a digit-validity function (nibble <= 9).
REQ-035 One sub-module is natural: dec_mult_seq_fsm (state register, digit counter, drain counter). Operand and result registers stay in the top module. The recoder itself is external and time-shared through rec_in/rec_out.

Verification
REQ-036 The bench uses a behavioural recoder (d < 5 -> d, else d + 3) and a behavioural accumulator delayed by ACC_LAT.
REQ-037 Directed scenarios:
- a = 16'h1234, b = 16'h5678, out_ready = 1 -> prod = 32'h07006652, err = 0, out_valid at T + 8 (ACC_LAT = 1).
- b = 16'h0102 -> pp_en pattern over issue cycles 0..3 = 1, 0, 1, 0; acc_shift = 0, 1, 1, 1.
- a = 16'h12A4 -> out_valid at T + 1, err = 1, prod = 0, no ISSUE cycles, acc_clr never pulses.
- out_ready held low for 5 cycles in DONE -> prod/out_valid stable; in_valid asserted meanwhile is not accepted.
- rst pulsed during ISSUE (i = 2) -> outputs at reset values next cycle; next pair 16'h9999 x 16'h9999 -> prod = 32'h99980001.
- ACC_LAT = 0 and ACC_LAT = 7 builds -> out_valid at T + 7 and T + 14 respectively.
